// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 3-stage core: PC/IF-ID/ID-EX advance, hold and flush
// control, multi-cycle EX tracking and saturating stall/flush counters.
//
// state   | meaning
// RUN     | normal operation, hazards and redirects evaluated every cycle
// MC_WAIT | multi-cycle EX op in flight, front end frozen until mc_done
// JFLUSH  | cycle after a redirect, ID and EX hold bubbles
module pipe_hazard_ctrl #(
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [REG_W-1:0]  id_rs1_addr,
   input  logic [REG_W-1:0]  id_rs2_addr,
   input  logic              id_rs1_re,
   input  logic              id_rs2_re,
   input  logic [REG_W-1:0]  ex_rd_addr,
   input  logic              ex_mem_read,
   input  logic              ex_jump_req,
   input  logic [ADDR_W-1:0] ex_jump_addr,
   input  logic              ex_mc_start,
   input  logic              mc_done,
   input  logic              bus_wait,
   output logic              pc_hold,
   output logic              pc_jump,
   output logic [ADDR_W-1:0] pc_jump_addr,
   output logic              if_id_nop,
   output logic              if_id_jump,
   output logic              id_ex_flush,
   output logic              id_ex_hold,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [15:0]       flush_cnt
);

   typedef enum logic [1:0] {RUN, MC_WAIT, JFLUSH} state_t;

   state_t state;
   state_t state_nxt;
   logic   load_use;

   assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                     ((id_rs1_re && (id_rs1_addr == ex_rd_addr)) ||
                      (id_rs2_re && (id_rs2_addr == ex_rd_addr)));

   always_comb begin
      state_nxt   = state;
      pc_hold     = 1'b0;
      pc_jump     = 1'b0;
      if_id_nop   = 1'b0;
      if_id_jump  = 1'b0;
      id_ex_flush = 1'b0;
      id_ex_hold  = 1'b0;
      case (state)
         RUN: begin
            if (ex_jump_req) begin
               pc_jump     = 1'b1;
               if_id_jump  = 1'b1;
               id_ex_flush = 1'b1;
               state_nxt   = JFLUSH;
            end else if (ex_mc_start) begin
               // a same-cycle mc_done means the op finished in one cycle
               if (!mc_done) begin
                  pc_hold    = 1'b1;
                  if_id_nop  = 1'b1;
                  id_ex_hold = 1'b1;
                  state_nxt  = MC_WAIT;
               end
            end else if (load_use || bus_wait) begin
               pc_hold     = 1'b1;
               if_id_nop   = 1'b1;
               id_ex_flush = 1'b1;
            end
         end
         MC_WAIT: begin
            if (mc_done) begin
               state_nxt = RUN;
            end else begin
               pc_hold    = 1'b1;
               if_id_nop  = 1'b1;
               id_ex_hold = 1'b1;
            end
         end
         JFLUSH: begin
            if (bus_wait) begin
               pc_hold     = 1'b1;
               if_id_nop   = 1'b1;
               id_ex_flush = 1'b1;
            end
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
      if (!rstn) begin
         state_nxt   = RUN;
         pc_hold     = 1'b0;
         pc_jump     = 1'b0;
         if_id_nop   = 1'b0;
         if_id_jump  = 1'b0;
         id_ex_flush = 1'b0;
         id_ex_hold  = 1'b0;
      end
   end

   assign pc_jump_addr = pc_jump ? ex_jump_addr : '0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (pc_hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (pc_jump && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected controls queued per step and
// compared at the falling edge; counters tracked by a saturating model.
module tb_pipe_hazard_ctrl;

   localparam logic [5:0] IDLE = 6'b000000;  // {pc_hold,pc_jump,if_id_nop,if_id_jump,id_ex_flush,id_ex_hold}
   localparam logic [5:0] BUB  = 6'b101010;
   localparam logic [5:0] HLD  = 6'b101001;
   localparam logic [5:0] JMP  = 6'b010110;

   typedef struct {
      logic [5:0]  ctrl;
      logic [31:0] addr;
   } exp_t;

   logic        clk, rstn;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_rs1_re, id_rs2_re, ex_mem_read, ex_jump_req, ex_mc_start, mc_done, bus_wait;
   logic [31:0] ex_jump_addr;

   logic        pc_hold, pc_jump, if_id_nop, if_id_jump, id_ex_flush, id_ex_hold;
   logic [31:0] pc_jump_addr, stall_cnt;
   logic [15:0] flush_cnt;

   logic        pc_hold4, pc_jump4, if_id_nop4, if_id_jump4, id_ex_flush4, id_ex_hold4;
   logic [31:0] pc_jump_addr4;
   logic [3:0]  stall_cnt4;
   logic [15:0] flush_cnt4;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_stall;
   logic [3:0]  exp_stall4;
   logic [15:0] exp_flush;

   pipe_hazard_ctrl dut (
      .clk(clk), .rstn(rstn),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
      .ex_mc_start(ex_mc_start), .mc_done(mc_done), .bus_wait(bus_wait),
      .pc_hold(pc_hold), .pc_jump(pc_jump), .pc_jump_addr(pc_jump_addr),
      .if_id_nop(if_id_nop), .if_id_jump(if_id_jump),
      .id_ex_flush(id_ex_flush), .id_ex_hold(id_ex_hold),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rstn(rstn),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
      .ex_mc_start(ex_mc_start), .mc_done(mc_done), .bus_wait(bus_wait),
      .pc_hold(pc_hold4), .pc_jump(pc_jump4), .pc_jump_addr(pc_jump_addr4),
      .if_id_nop(if_id_nop4), .if_id_jump(if_id_jump4),
      .id_ex_flush(id_ex_flush4), .id_ex_hold(id_ex_hold4),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_re = 1'b0; id_rs2_re = 1'b0;
      ex_rd_addr = '0; ex_mem_read = 1'b0; ex_jump_req = 1'b0; ex_jump_addr = '0;
      ex_mc_start = 1'b0; mc_done = 1'b0; bus_wait = 1'b0;
   endtask

   // one clock: queue expectation, compare at negedge, advance counter model
   task automatic cycle(input string tag, input logic [5:0] ev, input logic [31:0] ea, input bit cc);
      exp_t e;
      e.ctrl = ev;
      e.addr = ea;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".ctrl"}, 32'({pc_hold, pc_jump, if_id_nop, if_id_jump, id_ex_flush, id_ex_hold}), 32'(e.ctrl));
      chk({tag, ".addr"}, pc_jump_addr, e.addr);
      if (cc) begin
         chk({tag, ".stall"}, stall_cnt, exp_stall);
         chk({tag, ".stall4"}, 32'(stall_cnt4), 32'(exp_stall4));
         chk({tag, ".flush"}, 32'(flush_cnt), 32'(exp_flush));
      end
      if (!rstn) begin
         exp_stall = '0; exp_stall4 = '0; exp_flush = '0;
      end else begin
         if (e.ctrl[5]) begin
            if (exp_stall != 32'hffff_ffff) exp_stall++;
            if (exp_stall4 != 4'hf) exp_stall4++;
         end
         if (e.ctrl[4] && exp_flush != 16'hffff) exp_flush++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rstn = 1'b0;
      exp_stall = '0; exp_stall4 = '0; exp_flush = '0;
      @(posedge clk);
      #1;
      cycle("rst0", IDLE, 0, 0);
      cycle("rst1", IDLE, 0, 1);
      rstn = 1'b1;
      cycle("idle", IDLE, 0, 1);

      // load-use on rs2, then EX holds the bubble
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_re = 1'b1; id_rs2_addr = 5'd5;
      cycle("lu_rs2", BUB, 0, 1);
      ex_mem_read = 1'b0;
      cycle("lu_clear", IDLE, 0, 1);
      ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
      cycle("lu_x0", IDLE, 0, 1);
      clr();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_re = 1'b1; id_rs1_addr = 5'd7;
      cycle("lu_rs1", BUB, 0, 1);
      id_rs1_re = 1'b0;
      cycle("lu_no_re", IDLE, 0, 1);

      // redirect with load-use also present; JFLUSH suppresses LU
      clr();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_re = 1'b1; id_rs2_addr = 5'd5;
      ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0100;
      cycle("jump", JMP, 32'h100, 1);
      ex_jump_req = 1'b0;
      cycle("jflush_lu", IDLE, 0, 1);
      cycle("run_lu", BUB, 0, 1);
      clr();
      ex_jump_req = 1'b1; ex_jump_addr = 32'hdead_beec;
      cycle("jump2", JMP, 32'hdead_beec, 1);
      ex_jump_req = 1'b0; bus_wait = 1'b1;
      cycle("jflush_bw", BUB, 0, 1);
      bus_wait = 1'b0;
      cycle("after_jf", IDLE, 0, 1);

      // 34-cycle multi-cycle op with ignored jump/bus_wait mid-wait
      ex_mc_start = 1'b1;
      cycle("mc_start", HLD, 0, 1);
      ex_mc_start = 1'b0;
      for (int i = 1; i < 34; i++) begin
         ex_jump_req = (i == 10); ex_jump_addr = 32'h200;
         bus_wait = (i == 20);
         cycle("mc_wait", HLD, 0, 1);
      end
      clr(); mc_done = 1'b1;
      cycle("mc_done", IDLE, 0, 1);
      mc_done = 1'b0;
      cycle("mc_after", IDLE, 0, 1);

      // single-cycle completion stays in RUN
      ex_mc_start = 1'b1; mc_done = 1'b1;
      cycle("mc_1cyc", IDLE, 0, 1);
      clr();
      cycle("mc_1cyc_nx", IDLE, 0, 1);

      // bus_wait burst of three
      bus_wait = 1'b1;
      for (int i = 0; i < 3; i++) cycle("bus_wait", BUB, 0, 1);
      bus_wait = 1'b0;
      cycle("bw_end", IDLE, 0, 1);

      // reset in the middle of MC_WAIT, then stray mc_done
      ex_mc_start = 1'b1;
      cycle("mc2_start", HLD, 0, 1);
      ex_mc_start = 1'b0;
      for (int i = 0; i < 3; i++) cycle("mc2_wait", HLD, 0, 1);
      rstn = 1'b0;
      cycle("mc2_rst", IDLE, 0, 1);
      rstn = 1'b1;
      cycle("post_rst", IDLE, 0, 1);
      mc_done = 1'b1;
      cycle("stray_done", IDLE, 0, 1);
      mc_done = 1'b0;

      // 20 stalls: narrow counter saturates at 15
      bus_wait = 1'b1;
      for (int i = 0; i < 20; i++) cycle("sat", BUB, 0, 1);
      bus_wait = 1'b0;
      cycle("sat_end", IDLE, 0, 1);
      chk("stall4_sat", 32'(stall_cnt4), 32'd15);
      chk("stall_20", stall_cnt, 32'd20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 3-stage core.
- Decides each cycle whether PC, IF/ID and ID/EX advance, hold, or flush.
- Produces the nop/jump controls consumed by the IF/ID register, the PC hold/redirect, and the ID/EX bubble/hold.
- Tracks multi-cycle EX operations (divider) and keeps saturating stall/flush performance counters.

Parameters:
ADDR_W, 32, PC / jump-target width
REG_W, 5, register-index width
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
id_rs1_addr  in  REG_W  source reg 1 of instruction in ID
id_rs2_addr  in  REG_W  source reg 2 of instruction in ID
id_rs1_re  in  1  ID reads rs1
id_rs2_re  in  1  ID reads rs2
ex_rd_addr  in  REG_W  destination reg of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_jump_req  in  1  EX resolved a taken branch/jump
ex_jump_addr  in  ADDR_W  redirect target
ex_mc_start  in  1  EX issued a multi-cycle op this cycle
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
bus_wait  in  1  instruction fetch not ready
pc_hold  out  1  PC keeps value
pc_jump  out  1  PC loads pc_jump_addr
pc_jump_addr  out  ADDR_W  redirect target
if_id_nop  out  1  IF/ID hold
if_id_jump  out  1  IF/ID flush
id_ex_flush  out  1  ID/EX loads bubble
id_ex_hold  out  1  ID/EX keeps value
stall_cnt  out  CNT_W  cycles with pc_hold=1
flush_cnt  out  16  taken redirects

Behaviour:
- Control outputs are combinational from inputs plus state, effective the same cycle. Counters are registered.
- While rstn=0: all outputs 0, state RUN, counters 0.
- States:
  - RUN: normal operation.
  - MC_WAIT: waiting on a multi-cycle op.
  - JFLUSH: one cycle after a redirect.
- Load-use hazard (LU) = ex_mem_read & ex_rd_addr!=0 & ((id_rs1_re & rs1==rd) | (id_rs2_re & rs2==rd)).
- RUN, priority order:
  1. ex_jump_req: pc_jump=1, pc_jump_addr=ex_jump_addr, if_id_jump=1, id_ex_flush=1; next state JFLUSH. LU, bus_wait and ex_mc_start are ignored this cycle. Jump+mc_start together is illegal; jump wins.
  2. ex_mc_start: pc_hold=1, if_id_nop=1, id_ex_hold=1; next state MC_WAIT. If mc_done is also 1 this cycle (single-cycle completion), stay RUN and assert no hold.
  3. LU or bus_wait: pc_hold=1, if_id_nop=1, id_ex_flush=1 (one bubble per cycle); stay RUN. LU clears the next cycle because EX then holds the bubble.
  4. Otherwise all controls 0.
- MC_WAIT:
  - While mc_done=0: pc_hold, if_id_nop, id_ex_hold = 1. ex_jump_req, LU and bus_wait are ignored.
  - On mc_done=1: all holds 0 this cycle; next state RUN. EX advances with the result.
- JFLUSH:
  - ID holds the NOP inserted by IF/ID, so LU is suppressed.
  - bus_wait → pc_hold=1, if_id_nop=1, id_ex_flush=1.
  - A new ex_jump_req is impossible (EX holds a bubble) and is ignored.
  - Next state RUN.
- pc_jump_addr = ex_jump_addr when pc_jump=1, else 0.
- Counters:
  - stall_cnt increments by 1 on every clock with pc_hold=1.
  - flush_cnt increments by 1 on every pc_jump=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-MC_WAIT: return to RUN. A later stray mc_done in RUN is ignored.
- pc_hold and pc_jump are never both 1. id_ex_flush and id_ex_hold are never both 1.

Test Plan:
- Load x5 in EX (ex_mem_read=1, rd=5); ID reads rs2=5 → exactly 1 cycle of pc_hold=if_id_nop=id_ex_flush=1; stall_cnt 0→1.
- Same stimulus with rd=0 → no stall.
- ex_jump_req=1, addr=0x0000_0100, with LU also true → pc_jump=1, pc_jump_addr=0x100, if_id_jump=1, id_ex_flush=1, pc_hold=0; next cycle JFLUSH with no stall; flush_cnt=1.
- ex_mc_start then mc_done 34 cycles later → pc_hold/if_id_nop/id_ex_hold high for exactly 34 cycles; ex_jump_req pulsed mid-wait is ignored; stall_cnt=34.
- ex_mc_start and mc_done in the same cycle → no hold, state stays RUN.
- bus_wait high 3 cycles during RUN → 3 bubble cycles. Reset asserted during MC_WAIT → all outputs 0 next cycle, counters 0.
- Force stall_cnt near max (CNT_W=4 build) with 20 stall cycles → saturates at 15.
